uart_transmitter: RTL and testbench

- Serial transmit stage directly downstream of the transmit baud controller.
- Consumes the controller's one-clock `sample_ENABLE` pulse, which runs at 16× the selected baud rate.
- Serialises one parallel byte per frame onto `Tx_D`: start bit, data bits LSB first, even parity bit, stop bit.
- Each bit lasts OVERSAMPLE `sample_ENABLE` pulses. A busy flag gives simple write handshaking to the host side.

---
 rtl/uart_transmitter_if.sv | 21 ++
 rtl/uart_transmitter.sv | 110 +++++++++++
 tb/tb_uart_transmitter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_transmitter_if.sv
// Host-side signal bundle for the UART transmit stage: baud tick, write handshake and serial output.
interface uart_transmitter_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  sample_ENABLE;
    logic                  Tx_EN;
    logic                  Tx_WR;
    logic [DATA_WIDTH-1:0] Tx_DATA;
    logic                  Tx_D;
    logic                  Tx_BUSY;

    modport master (
        output sample_ENABLE, Tx_EN, Tx_WR, Tx_DATA,
        input  Tx_D, Tx_BUSY
    );

    modport slave (
        input  sample_ENABLE, Tx_EN, Tx_WR, Tx_DATA,
        output Tx_D, Tx_BUSY
    );
endinterface

// File: rtl/uart_transmitter.sv
// UART transmit serialiser: start, LSB-first data, parity and stop bits, each OVERSAMPLE baud ticks long.
//
// state  | meaning
// IDLE   | line high, waiting for an accepted write
// START  | driving the start bit (low)
// DATA   | driving shift register bit 0, DATA_WIDTH bits
// PARITY | driving the latched parity bit
// STOP   | driving the stop bit (high)
module uart_transmitter #(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter bit PARITY_EVEN = 1'b1
) (
    input logic clock,
    input logic reset,
    uart_transmitter_if.slave bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         tick_cnt, tick_cnt_nxt;
    logic [BW-1:0]         bit_idx, bit_idx_nxt;
    logic [DATA_WIDTH-1:0] shift_reg, shift_reg_nxt;
    logic                  parity_bit, parity_bit_nxt;
    logic                  tx_d, tx_d_nxt;
    logic                  tx_busy, tx_busy_nxt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_d       <= 1'b1;
            tx_busy    <= 1'b0;
        end else begin
            state      <= state_nxt;
            tick_cnt   <= tick_cnt_nxt;
            bit_idx    <= bit_idx_nxt;
            shift_reg  <= shift_reg_nxt;
            parity_bit <= parity_bit_nxt;
            tx_d       <= tx_d_nxt;
            tx_busy    <= tx_busy_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        tick_cnt_nxt   = tick_cnt;
        bit_idx_nxt    = bit_idx;
        shift_reg_nxt  = shift_reg;
        parity_bit_nxt = parity_bit;

        // Disable wins over everything, including a bit-end tick in the same cycle.
        if (!bus.Tx_EN) begin
            state_nxt    = IDLE;
            tick_cnt_nxt = '0;
            bit_idx_nxt  = '0;
        end else if (state == IDLE) begin
            if (bus.Tx_WR) begin
                shift_reg_nxt  = bus.Tx_DATA;
                parity_bit_nxt = (^bus.Tx_DATA) ^ ~PARITY_EVEN;
                tick_cnt_nxt   = '0;
                bit_idx_nxt    = '0;
                state_nxt      = START;
            end
        end else if (bus.sample_ENABLE) begin
            if (tick_cnt != TICK_LAST) begin
                tick_cnt_nxt = tick_cnt + 1'b1;
            end else begin
                tick_cnt_nxt = '0;
                case (state)
                    START:   state_nxt = DATA;
                    DATA: begin
                        shift_reg_nxt = shift_reg >> 1;
                        bit_idx_nxt   = bit_idx + 1'b1;
                        if (bit_idx == BIT_LAST) state_nxt = PARITY;
                    end
                    PARITY:  state_nxt = STOP;
                    STOP:    state_nxt = IDLE;
                    default: state_nxt = IDLE;
                endcase
            end
        end

        // Outputs are decoded from the next state so the line register changes on the same edge as the state.
        tx_busy_nxt = (state_nxt != IDLE);
        case (state_nxt)
            START:   tx_d_nxt = 1'b0;
            DATA:    tx_d_nxt = shift_reg_nxt[0];
            PARITY:  tx_d_nxt = parity_bit_nxt;
            default: tx_d_nxt = 1'b1;
        endcase
    end

    assign bus.Tx_D    = tx_d;
    assign bus.Tx_BUSY = tx_busy;
endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: even- and odd-parity instances share stimulus; frames are decoded mid-bit.
module tb_uart_transmitter;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       s_en  = 1'b0;
    logic       tx_en = 1'b0;
    logic       tx_wr = 1'b0;
    logic [7:0] tx_data = 8'h00;
    bit         rand_mode = 1'b0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    always #5 clock = ~clock;

    uart_transmitter_if #(.DATA_WIDTH(8)) bus_e ();
    uart_transmitter_if #(.DATA_WIDTH(8)) bus_o ();

    assign bus_e.sample_ENABLE = s_en;
    assign bus_e.Tx_EN         = tx_en;
    assign bus_e.Tx_WR         = tx_wr;
    assign bus_e.Tx_DATA       = tx_data;
    assign bus_o.sample_ENABLE = s_en;
    assign bus_o.Tx_EN         = tx_en;
    assign bus_o.Tx_WR         = tx_wr;
    assign bus_o.Tx_DATA       = tx_data;

    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EVEN(1'b1)) dut_e (
        .clock(clock), .reset(reset), .bus(bus_e)
    );
    uart_transmitter #(.DATA_WIDTH(8), .OVERSAMPLE(16), .PARITY_EVEN(1'b0)) dut_o (
        .clock(clock), .reset(reset), .bus(bus_o)
    );

    // Baud tick: every 4th clock, or random density in the randomized phase. Changes on negedge only.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (rand_mode) s_en = ($urandom_range(0, 3) == 0);
            else           s_en = (cyc % 4 == 0);
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: parity from a population count, not from an XOR reduction.
    function automatic logic model_parity(input logic [7:0] d, input bit even);
        int ones;
        ones = $countones(d);
        return even ? logic'(ones % 2) : logic'(1 - (ones % 2));
    endfunction

    function automatic logic [3:0] outs();
        return {bus_e.Tx_D, bus_o.Tx_D, bus_e.Tx_BUSY, bus_o.Tx_BUSY};
    endfunction

    task automatic expect_idle(input string name, input int n);
        int bad;
        bad = 0;
        repeat (n) begin
            @(posedge clock);
            #1;
            if (outs() !== 4'b1100) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Runs one frame and checks each bit at its midpoint, counting ticks from the accepting edge.
    task automatic run_frame(input string name, input logic [7:0] d, input logic pe, input logic po,
                             input bit do_write, input int wr_busy_tick, input int abort_tick,
                             input int reset_tick, input bit chain, input logic [7:0] chain_data);
        logic [10:0] exp_e;
        logic [10:0] exp_o;
        logic        t;
        int          tick;
        int          k;
        bit          done;
        exp_e = {1'b1, pe, d, 1'b0};
        exp_o = {1'b1, po, d, 1'b0};
        if (do_write) begin
            @(negedge clock);
            tx_wr   = 1'b1;
            tx_data = d;
        end
        @(posedge clock);
        #1;
        tx_wr   = 1'b0;
        tx_data = 8'($urandom);
        chk({name, ":accept"}, outs(), 4'b0011);
        tick = 0;
        done = 1'b0;
        for (int c = 0; c < 6000 && !done; c++) begin
            @(posedge clock);
            t = s_en;
            #1;
            if (tx_wr) tx_wr = 1'b0;
            if (!t) continue;
            tick++;
            if (tick % 16 == 8) begin
                k = tick / 16;
                chk($sformatf("%s:bit%0d", name, k), {bus_e.Tx_D, bus_o.Tx_D}, {exp_e[k], exp_o[k]});
            end
            if (tick == wr_busy_tick) begin
                tx_wr   = 1'b1;
                tx_data = 8'h3C;
            end
            if (tick == abort_tick) begin
                tx_en = 1'b0;
                @(posedge clock);
                #1;
                chk({name, ":abort"}, outs(), 4'b1100);
                tx_en = 1'b1;
                done  = 1'b1;
            end else if (tick == reset_tick) begin
                #2;
                reset = 1'b0;
                #1;
                chk({name, ":async_reset"}, outs(), 4'b1100);
                @(negedge clock);
                reset = 1'b1;
                done  = 1'b1;
            end else if (tick == 175) begin
                chk({name, ":busy_last_tick"}, {bus_e.Tx_BUSY, bus_o.Tx_BUSY}, 2'b11);
            end else if (tick == 176) begin
                chk({name, ":end"}, outs(), 4'b1100);
                if (chain) begin
                    tx_wr   = 1'b1;
                    tx_data = chain_data;
                end
                done = 1'b1;
            end
        end
        if (!done) chk({name, ":timeout"}, 1, 0);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_e;
        logic       par_o;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [7:0] d;
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b0, 1'b1};
        vecs[3] = '{8'h55, 1'b0, 1'b1};
        vecs[4] = '{8'h0F, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b0};
        vecs[6] = '{8'h3C, 1'b0, 1'b1};

        tx_en = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", outs(), 4'b1100);
        @(negedge clock);
        reset = 1'b1;
        expect_idle("idle_after_reset", 8);

        // Table frames; the A5 frame carries a write-while-busy that must be dropped.
        for (int i = 0; i < 7; i++) begin
            run_frame($sformatf("tbl%0d_%02h", i, vecs[i].data), vecs[i].data, vecs[i].par_e,
                      vecs[i].par_o, 1'b1, (i == 0) ? 40 : -1, -1, -1, 1'b0, 8'h00);
            expect_idle($sformatf("tbl%0d_idle", i), 60);
        end

        run_frame("pre_b2b", 8'hA5, 1'b0, 1'b1, 1'b1, -1, -1, -1, 1'b1, 8'h55);
        run_frame("b2b_55", 8'h55, 1'b0, 1'b1, 1'b0, -1, -1, -1, 1'b0, 8'h00);
        expect_idle("b2b_idle", 20);

        run_frame("abort", 8'hC3, 1'b0, 1'b1, 1'b1, -1, 70, -1, 1'b0, 8'h00);
        expect_idle("abort_idle", 20);
        run_frame("after_abort_0F", 8'h0F, 1'b0, 1'b1, 1'b1, -1, -1, -1, 1'b0, 8'h00);

        run_frame("reset_mid", 8'h96, 1'b0, 1'b1, 1'b1, -1, -1, 150, 1'b0, 8'h00);
        expect_idle("post_reset_idle", 200);

        rand_mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d = 8'($urandom);
            run_frame($sformatf("rand%0d_%02h", i, d), d, model_parity(d, 1'b1), model_parity(d, 1'b0),
                      1'b1, -1, -1, -1, 1'b0, 8'h00);
            repeat ($urandom_range(0, 20)) @(negedge clock);
        end
        expect_idle("final_idle", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
